pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It combines the ID-stage hazard flag, the ID-stage branch decision and the MEM-stage memory handshake into per-stage freeze, bubble and flush controls. It watchdogs slow memory accesses and keeps saturating performance counters. It sits beside the hazard detection unit and drives the enables and clears of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

## Interface
- `TIMEOUT`, default 64: number of consecutive frozen cycles without `mem_ready` before the block halts; legal range 2..65535.
- `CNT_W`, default 32: width of each performance counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `hazard_detected` input 1: RAW hazard flagged for the instruction in ID.
- `branch_taken` input 1: branch/jump in ID resolved as taken.
- `mem_req` input 1: MEM stage holds a load or store.
- `mem_ready` input 1: memory completes the MEM-stage access this cycle.
- `clr_cnt` input 1: synchronous clear of all performance counters.
- `freeze_front` output 1: hold the PC and IF/ID registers.
- `bubble_exe` output 1: load a NOP into ID/EXE, with WB_EN and MEM controls forced to 0.
- `flush_if` output 1: clear IF/ID to a NOP.
- `freeze_all` output 1: hold every pipeline register, including the PC.
- `mem_timeout` output 1: sticky error flag; the block is in HALT.
- `stall_cnt` output CNT_W: number of hazard bubble cycles.
- `flush_cnt` output CNT_W: number of branch flushes.
- `memwait_cnt` output CNT_W: number of memory-frozen cycles.

## Operation
- States:
  - RUN (reset state).
  - MEM_WAIT.
  - HALT.
- Control priority, evaluated combinationally each cycle:
  1. Memory freeze. `freeze_all` = (RUN & `mem_req` & !`mem_ready`) | (MEM_WAIT & !`mem_ready`) | HALT.
  2. Hazard. When `freeze_all`=0 and `hazard_detected`=1: `freeze_front`=1 and `bubble_exe`=1. `branch_taken` is ignored this cycle because the branch operands are not yet valid.
  3. Branch. When `freeze_all`=0, `hazard_detected`=0 and `branch_taken`=1: `flush_if`=1.
- When `freeze_all`=1, the outputs `freeze_front`, `bubble_exe` and `flush_if` are all 0.
- Transitions:
  - RUN → MEM_WAIT when `mem_req` & !`mem_ready`. `wait_cnt` is loaded with 1.
  - MEM_WAIT → RUN when `mem_ready`=1. `freeze_all` is already 0 in that cycle, so the access retires.
  - MEM_WAIT with !`mem_ready`: if `wait_cnt`==TIMEOUT, go to HALT. Otherwise `wait_cnt`+1.
  - HALT → HALT until `rst`. `mem_timeout`=1 and `freeze_all`=1 throughout.
- `wait_cnt` is 16 bits and internal. It equals the number of frozen cycles in the current access.
- Counters:
  - `stall_cnt` increments in every cycle with `bubble_exe`=1.
  - `flush_cnt` increments in every cycle with `flush_if`=1.
  - `memwait_cnt` increments in every cycle with `freeze_all`=1, including cycles in HALT.
  - All three saturate at 2^CNT_W−1.
  - `clr_cnt` zeroes all three. If `clr_cnt` coincides with an increment, the result is 0.
  - `clr_cnt` does not affect the FSM.

## Timing
- Control outputs are combinational from the inputs and the registered state, with zero latency. They are valid in the same cycle as the condition that causes them.
- `mem_timeout` is registered. It rises in the first cycle of HALT, which is TIMEOUT+1 cycles after the first frozen cycle.
- Counters are registered. Each count is visible on the cycle after the event that causes it.
- Reset values: state RUN, `wait_cnt`=0, `mem_timeout`=0, all counters 0.
- Combinational outputs while `rst`=1: all 0, regardless of the other inputs.
- Reset asserted mid-MEM_WAIT or in HALT returns the block to RUN on the next edge. Any in-flight access is abandoned.
- A one-cycle memory access (`mem_req` & `mem_ready` in RUN) causes no freeze and no state change.
- Back-to-back slow accesses: MEM_WAIT → RUN on `mem_ready`. A new access that misses in the next cycle re-enters MEM_WAIT with `wait_cnt` reloaded to 1.

## Structure
- The shared defines header holds:
  - The state encodings `ST_RUN`=2'd0, `ST_MEM_WAIT`=2'd1 and `ST_HALT`=2'd2.
  - The default timeout and counter width constants, so the top level and the benches use the same values.
- One sub-module, `sat_counter`, parameterised by width, with `clk`, `rst`, `clr` and `inc` inputs and a count output. It is instantiated three times for the performance counters.
- The FSM, `wait_cnt` and the priority logic live in the top-level module.

## Test plan
- Hazard alone: `hazard_detected`=1 for 2 cycles in RUN with `mem_req`=0 → `freeze_front`=`bubble_exe`=1 in both cycles, `flush_if`=0, and `stall_cnt`=2 afterwards.
- Hazard and branch together: `hazard_detected`=1 and `branch_taken`=1 in the same cycle → bubble only, `flush_if`=0. The next cycle has `branch_taken`=1 only → `flush_if`=1 and `flush_cnt`=1.
- Slow memory: `mem_req`=1 with `mem_ready` low for 3 cycles, then high → `freeze_all`=1 for exactly 3 cycles, state returns to RUN, and `memwait_cnt`=3. A `hazard_detected` pulse during the freeze produces no bubble.
- Timeout: TIMEOUT=4 and `mem_ready` held low → `freeze_all` stays high, `mem_timeout` rises in cycle 5, and `rst` pulsed for one cycle returns all outputs to 0.
- Counter saturation and clear: CNT_W=3 and 9 bubble cycles → `stall_cnt`=7. `clr_cnt` asserted during a bubble cycle → 0.
- Reset mid-wait: `rst` asserted in the second MEM_WAIT cycle → state RUN, `freeze_all`=0 once `rst` is released with `mem_req`=0.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encodings and default sizing for the pipeline stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipeline_stall_controller_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   // Default frozen-cycle budget before halting, and default counter width
   localparam int DEF_TIMEOUT = 64;
   localparam int DEF_CNT_W   = 32;

   // Width of the internal frozen-cycle counter
   localparam int WAIT_W = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// Latency: count visible the cycle after the increment event.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   // Clear wins over a coincident increment; stop at the maximum value
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges hazard, branch and memory handshake into per-stage controls.
// Latency: controls are combinational (same cycle); mem_timeout and counters are registered.
// Backpressure: an unfinished MEM access freezes the whole pipeline; a long wait halts until reset.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_cnt,
   output logic             freeze_front,
   output logic             bubble_exe,
   output logic             flush_if,
   output logic             freeze_all,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
);

   localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT);

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_mem_timeout;

   logic w_freeze_all;
   logic w_freeze_front;
   logic w_bubble_exe;
   logic w_flush_if;

   // Priority: memory freeze, then hazard bubble, then branch flush; all quiet in reset
   always_comb begin
      w_freeze_all   = 1'b0;
      w_freeze_front = 1'b0;
      w_bubble_exe   = 1'b0;
      w_flush_if     = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_RUN:      w_freeze_all = mem_req & ~mem_ready;
            ST_MEM_WAIT: w_freeze_all = ~mem_ready;
            ST_HALT:     w_freeze_all = 1'b1;
            default:     w_freeze_all = 1'b0;
         endcase
         if (!w_freeze_all) begin
            if (hazard_detected) begin
               // Branch operands are not valid yet, so a taken branch waits for the bubble
               w_freeze_front = 1'b1;
               w_bubble_exe   = 1'b1;
            end else if (branch_taken) begin
               w_flush_if = 1'b1;
            end
         end
      end
   end

   // Memory-wait sequencer with frozen-cycle watchdog and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (mem_req && !mem_ready) begin
                  r_state    <= ST_MEM_WAIT;
                  r_wait_cnt <= {{(WAIT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == TIMEOUT_LIM) begin
                  r_state       <= ST_HALT;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_HALT: begin
               r_state       <= ST_HALT;
               r_mem_timeout <= 1'b1;
            end
            default: begin
               r_state    <= ST_RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   assign freeze_all   = w_freeze_all;
   assign freeze_front = w_freeze_front;
   assign bubble_exe   = w_bubble_exe;
   assign flush_if     = w_flush_if;
   assign mem_timeout  = r_mem_timeout;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_cnt),
      .inc   (w_bubble_exe),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_cnt),
      .inc   (w_flush_if),
      .count (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_memwait_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_cnt),
      .inc   (w_freeze_all),
      .count (memwait_cnt)
   );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench with a per-cycle reference model of the stall controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_stall_controller;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 3;
   localparam longint CMAX = (longint'(1) << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             hazard_detected = 1'b0;
   logic             branch_taken = 1'b0;
   logic             mem_req = 1'b0;
   logic             mem_ready = 1'b0;
   logic             clr_cnt = 1'b0;
   logic             freeze_front;
   logic             bubble_exe;
   logic             flush_if;
   logic             freeze_all;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] memwait_cnt;

   int checks = 0;
   int errors = 0;

   pipeline_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .hazard_detected (hazard_detected),
      .branch_taken    (branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .clr_cnt         (clr_cnt),
      .freeze_front    (freeze_front),
      .bubble_exe      (bubble_exe),
      .flush_if        (flush_if),
      .freeze_all      (freeze_all),
      .mem_timeout     (mem_timeout),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt),
      .memwait_cnt     (memwait_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: frozen cycles in the current access, halt flag, counter values
   int     m_frz  = 0;
   bit     m_halt = 1'b0;
   longint m_stall = 0, m_flush = 0, m_mw = 0;

   // Expected {freeze_all, freeze_front, bubble_exe, flush_if} from model state and inputs
   function automatic logic [3:0] ctl_exp();
      logic fa;
      if (rst) return 4'b0000;
      if (m_halt) fa = 1'b1;
      else if (m_frz > 0) fa = !mem_ready;
      else fa = mem_req && !mem_ready;
      if (fa) return 4'b1000;
      if (hazard_detected) return 4'b0110;
      if (branch_taken) return 4'b0001;
      return 4'b0000;
   endfunction

   function automatic longint sat_inc(longint v, logic ev);
      if (ev && v < CMAX) return v + 1;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model on each rising edge using the inputs seen at that edge
   always @(posedge clk) begin
      logic [3:0] e;
      e = ctl_exp();
      if (rst) begin
         m_frz = 0; m_halt = 1'b0; m_stall = 0; m_flush = 0; m_mw = 0;
      end else begin
         if (clr_cnt) begin
            m_stall = 0; m_flush = 0; m_mw = 0;
         end else begin
            m_stall = sat_inc(m_stall, e[1]);
            m_flush = sat_inc(m_flush, e[0]);
            m_mw    = sat_inc(m_mw, e[3]);
         end
         if (!m_halt) begin
            if (e[3]) begin
               m_frz++;
               if (m_frz == TIMEOUT + 1) m_halt = 1'b1;
            end else begin
               m_frz = 0;
            end
         end
      end
   end

   // Compare every output against the model mid-cycle
   always @(negedge clk) begin
      logic [3:0] e;
      e = ctl_exp();
      chk("m_freeze_all",   longint'(freeze_all),   longint'(e[3]));
      chk("m_freeze_front", longint'(freeze_front), longint'(e[2]));
      chk("m_bubble_exe",   longint'(bubble_exe),   longint'(e[1]));
      chk("m_flush_if",     longint'(flush_if),     longint'(e[0]));
      chk("m_mem_timeout",  longint'(mem_timeout),  longint'(m_halt));
      chk("m_stall_cnt",    longint'(stall_cnt),    m_stall);
      chk("m_flush_cnt",    longint'(flush_cnt),    m_flush);
      chk("m_memwait_cnt",  longint'(memwait_cnt),  m_mw);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset with every input active: combinational outputs must stay low
      hazard_detected = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      mid();
      chk("rst_freeze_all", longint'(freeze_all), 0);
      chk("rst_bubble", longint'(bubble_exe), 0);
      chk("rst_flush", longint'(flush_if), 0);
      tick();
      hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
      mid();
      chk("rst_stall_cnt", longint'(stall_cnt), 0);
      chk("rst_timeout", longint'(mem_timeout), 0);
      tick();
      rst = 1'b0;

      // Hazard alone for two cycles
      hazard_detected = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mid();
         chk("haz_front", longint'(freeze_front), 1);
         chk("haz_bubble", longint'(bubble_exe), 1);
         chk("haz_flush", longint'(flush_if), 0);
         tick();
      end
      hazard_detected = 1'b0;
      mid();
      chk("haz_stall_cnt", longint'(stall_cnt), 2);

      // Hazard and branch together, then branch alone
      tick();
      hazard_detected = 1'b1; branch_taken = 1'b1;
      mid();
      chk("hb_bubble", longint'(bubble_exe), 1);
      chk("hb_flush", longint'(flush_if), 0);
      tick();
      hazard_detected = 1'b0;
      mid();
      chk("br_flush", longint'(flush_if), 1);
      tick();
      branch_taken = 1'b0;
      mid();
      chk("br_flush_cnt", longint'(flush_cnt), 1);

      // Slow memory: three frozen cycles, hazard pulse ignored during the freeze
      tick();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hazard_detected = (i == 1);
         mid();
         chk("mem_freeze", longint'(freeze_all), 1);
         chk("mem_no_bubble", longint'(bubble_exe), 0);
         tick();
      end
      hazard_detected = 1'b0; mem_ready = 1'b1;
      mid();
      chk("mem_release", longint'(freeze_all), 0);
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      mid();
      chk("mem_memwait_cnt", longint'(memwait_cnt), 3);
      chk("mem_stall_cnt", longint'(stall_cnt), 0);

      // Back-to-back slow accesses, then a one-cycle access
      tick();
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mid();
      chk("b2b_refreeze", longint'(freeze_all), 1);
      tick();
      mem_ready = 1'b1;
      tick();
      mid();
      chk("onecyc_nofreeze", longint'(freeze_all), 0);
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;

      // Timeout: halts after TIMEOUT+1 frozen cycles
      tick();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         mid();
         chk("to_freeze", longint'(freeze_all), 1);
         chk("to_timeout", longint'(mem_timeout), (k >= 5) ? 1 : 0);
         if (k == 6) chk("to_memwait_cnt", longint'(memwait_cnt), 6);
         if (k == 5) mem_ready = 1'b1;
         tick();
      end
      mem_ready = 1'b0;
      rst = 1'b1;
      mid();
      chk("to_rst_freeze", longint'(freeze_all), 0);
      tick();
      rst = 1'b0; mem_req = 1'b0;
      mid();
      chk("to_cleared", longint'(mem_timeout), 0);
      chk("to_cleared_freeze", longint'(freeze_all), 0);
      chk("to_cleared_cnt", longint'(memwait_cnt), 0);

      // Saturation: nine bubbles saturate a 3-bit counter, clear wins over increment
      tick();
      hazard_detected = 1'b1;
      repeat (9) tick();
      mid();
      chk("sat_stall_cnt", longint'(stall_cnt), 7);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0; hazard_detected = 1'b0;
      mid();
      chk("clr_stall_cnt", longint'(stall_cnt), 0);

      // Reset asserted in the second MEM_WAIT cycle
      tick();
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; mem_req = 1'b0;
      mid();
      chk("rstwait_freeze", longint'(freeze_all), 0);
      tick();
      hazard_detected = 1'b1;
      mid();
      chk("rstwait_run_bubble", longint'(bubble_exe), 1);
      tick();
      hazard_detected = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
